// File: rtl/bias_act_unit.sv
// rtl/bias_act_unit.sv - two-stage per-channel bias add, saturate and ReLU/bypass pipeline
module bias_act_unit #(
    parameter int LANES      = 8,
    parameter int DW         = 32,
    parameter int BIAS_DEPTH = 16,
    localparam int AW        = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [AW:0]         num_ch,
    input  logic                ch_clr,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [LANES*DW-1:0] src_data,
    input  logic                bias_wr_en,
    input  logic [AW-1:0]       bias_wr_addr,
    input  logic [LANES*DW-1:0] bias_wr_data,
    output logic                dst_valid,
    input  logic                dst_ready,
    output logic [LANES*DW-1:0] dst_data,
    output logic                dst_sat,
    output logic [AW-1:0]       ch_idx
);

    localparam int W = LANES * DW;

    logic [W-1:0]     bias_q [BIAS_DEPTH];
    logic [W-1:0]     bias_d [BIAS_DEPTH];
    logic [AW-1:0]    ch_idx_q, ch_idx_d;
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_data_q, s1_data_d;
    logic [LANES-1:0] s1_sat_q, s1_sat_d;
    logic             s1_relu_q, s1_relu_d;
    logic             dst_valid_q, dst_valid_d;
    logic [W-1:0]     dst_data_q, dst_data_d;
    logic             dst_sat_q, dst_sat_d;

    logic             s2_adv, s1_adv, accept;
    logic [AW:0]      eff_ch, ch_nxt;
    logic [W-1:0]     bias_rd, add_res, relu_res;
    logic [LANES-1:0] add_sat;
    logic [DW:0]      lane_sum [LANES];

    // Occupancy-based readiness keeps src_ready free of any src_valid dependency
    always_comb begin
        s2_adv    = !dst_valid_q || dst_ready;
        s1_adv    = !s1_valid_q || s2_adv;
        src_ready = rstn && enable && s1_adv;
        accept    = src_valid && src_ready;
    end

    always_comb begin
        eff_ch = num_ch;
        if (num_ch == '0) begin
            eff_ch = (AW+1)'(1);
        end else if (32'(num_ch) > 32'(BIAS_DEPTH)) begin
            eff_ch = (AW+1)'(BIAS_DEPTH);
        end
        ch_nxt   = {1'b0, ch_idx_q} + (AW+1)'(1);
        ch_idx_d = ch_idx_q;
        if (ch_clr) begin
            ch_idx_d = '0;
        end else if (accept) begin
            ch_idx_d = (ch_nxt >= eff_ch) ? '0 : ch_nxt[AW-1:0];
        end
    end

    always_comb begin
        bias_d = bias_q;
        if (bias_wr_en && (32'(bias_wr_addr) < 32'(BIAS_DEPTH))) begin
            bias_d[bias_wr_addr] = bias_wr_data;
        end
    end

    assign bias_rd = bias_q[ch_idx_q];

    // Sign-extended add one bit wide; a mismatch of the top two bits means overflow
    always_comb begin
        add_res = '0;
        add_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i] = {src_data[i*DW+DW-1], src_data[i*DW +: DW]}
                        + {bias_rd[i*DW+DW-1], bias_rd[i*DW +: DW]};
            if (lane_sum[i][DW] != lane_sum[i][DW-1]) begin
                add_sat[i]           = 1'b1;
                add_res[i*DW +: DW]  = lane_sum[i][DW] ? {1'b1, {(DW-1){1'b0}}}
                                                        : {1'b0, {(DW-1){1'b1}}};
            end else begin
                add_res[i*DW +: DW]  = lane_sum[i][DW-1:0];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_adv ? accept : s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        s1_relu_d  = s1_relu_q;
        if (accept) begin
            s1_relu_d = (mode == 2'b01);
            if (mode == 2'b10) begin
                s1_data_d = src_data;
                s1_sat_d  = '0;
            end else begin
                s1_data_d = add_res;
                s1_sat_d  = add_sat;
            end
        end
    end

    always_comb begin
        relu_res = s1_data_q;
        if (s1_relu_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (s1_data_q[i*DW+DW-1]) begin
                    relu_res[i*DW +: DW] = '0;
                end
            end
        end
    end

    always_comb begin
        dst_valid_d = s2_adv ? s1_valid_q : dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_sat_d   = dst_sat_q;
        if (s2_adv && s1_valid_q) begin
            dst_data_d = relu_res;
            dst_sat_d  = |s1_sat_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < BIAS_DEPTH; e++) begin
                bias_q[e] <= '0;
            end
            ch_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_q    <= '0;
            s1_relu_q   <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_sat_q   <= 1'b0;
        end else begin
            bias_q      <= bias_d;
            ch_idx_q    <= ch_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            s1_relu_q   <= s1_relu_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_sat_q   <= dst_sat_d;
        end
    end

    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign dst_sat   = dst_sat_q;
    assign ch_idx    = ch_idx_q;

endmodule
